// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter.
//
// Contents:
//   grant_t  - winner of the single RAM port in a cycle
//   tag_t    - identifies which requester owns a read in flight
//   FB_*     - framebuffer geometry (80x60 character cells)
package vga_fb_pkg;

    // Framebuffer geometry: one word per character cell.
    localparam int unsigned FB_COLS  = 32'd80;
    localparam int unsigned FB_ROWS  = 32'd60;
    localparam int unsigned FB_WORDS = 32'd4800;

    // Owner of the RAM port for one cycle.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_HOST  = 2'd2
    } grant_t;

    // Owner of a read that is travelling through the RAM.
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_HOST  = 2'd2
    } tag_t;

    // True when a tag marks a read whose data must be returned.
    function automatic logic is_read_tag(input tag_t tag);
        logic result;
        case (tag)
            TAG_FETCH: result = 1'b1;
            TAG_HOST:  result = 1'b1;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/vga_fb_tag_pipe.sv
// Fixed-depth shift register of read tags.
//
// A tag pushed in cycle t appears on out_tag in cycle t+DEPTH, so the
// owner of each read word is known exactly when the RAM presents it.
// Every cycle shifts (no stall), which keeps the latency constant.
//
// Ports:
//   clk      - clock
//   reset    - synchronous, active-high; clears every stage
//   flush    - synchronous clear of every stage without a full reset
//   in_tag   - tag entering stage 0 (TAG_NONE for no read)
//   out_tag  - tag leaving the last stage
module vga_fb_tag_pipe
    import vga_fb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t stage_r [DEPTH];

    // Shift tags one stage per cycle; reset or flush empties the pipe.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= TAG_NONE;
            end
        end else begin
            stage_r[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_tag = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter between VGA scanout fetches and a host port.
//
// Scanout fetches win the single RAM port whenever they request it, so
// the fetch-to-data latency is always RAM_LAT+2 cycles. The host uses
// every cycle the scanout leaves free. With MAX_WAIT != 0, a host that
// has been refused MAX_WAIT cycles in a row is served next, and a fetch
// arriving in that cycle is dropped and counted in miss_count.
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   fetch_req/fetch_addr             - scanout read pulse and address
//   fetch_valid/fetch_data           - scanout read response pulse and data
//   host_valid/host_ready            - host command handshake
//   host_we/host_addr/host_wdata     - host command fields
//   host_rvalid/host_rdata           - host read response pulse and data
//   mem_en/mem_we/mem_addr/mem_wdata - registered RAM command
//   mem_rdata                        - RAM read data, RAM_LAT after mem_en
//   miss_count                       - saturating count of dropped fetches
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int RAM_LAT  = 1,
    parameter int MAX_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        miss_count
);

    // Wide enough to hold MAX_WAIT; a 1-bit counter when the guard is off.
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    // One stage for the registered command, RAM_LAT for the RAM itself.
    localparam int PIPE_DEPTH = RAM_LAT + 1;

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              force_s;
    logic              host_ready_s;
    logic              handshake_s;
    logic              drop_s;
    grant_t            grant_s;
    tag_t              push_tag_s;
    tag_t              pipe_tag_s;

    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              fetch_valid_r;
    logic [DATA_W-1:0] fetch_data_r;
    logic              host_rvalid_r;
    logic [DATA_W-1:0] host_rdata_r;
    logic [7:0]        miss_count_r;

    // Starvation guard: force only when enabled, saturated and still wanted.
    always_comb begin
        force_s = 1'b0;
        if ((MAX_WAIT != 0) && (wait_cnt_r == WAIT_MAX) && host_valid) begin
            force_s = 1'b1;
        end else begin
            force_s = 1'b0;
        end
    end

    // host_ready deliberately ignores host_valid (apart from force_s) so
    // the host may use it to decide whether to present a command.
    assign host_ready_s = (!fetch_req || force_s) && !reset;
    assign handshake_s  = host_valid && host_ready_s;
    assign drop_s       = fetch_req && force_s;

    // Pick at most one owner of the RAM port for this cycle.
    always_comb begin
        grant_s = GNT_IDLE;
        if (fetch_req && !force_s) begin
            grant_s = GNT_FETCH;
        end else if (host_valid && (!fetch_req || force_s)) begin
            grant_s = GNT_HOST;
        end else begin
            grant_s = GNT_IDLE;
        end
    end

    // Tag each read so its data can be routed when it leaves the RAM;
    // host writes have no response and carry no tag.
    always_comb begin
        push_tag_s = TAG_NONE;
        case (grant_s)
            GNT_FETCH: push_tag_s = TAG_FETCH;
            GNT_HOST: begin
                if (host_we) begin
                    push_tag_s = TAG_NONE;
                end else begin
                    push_tag_s = TAG_HOST;
                end
            end
            default: push_tag_s = TAG_NONE;
        endcase
    end

    // Register the winning command onto the RAM port; address and data
    // hold when idle so the RAM inputs do not toggle needlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            case (grant_s)
                GNT_FETCH: begin
                    mem_en_r   <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= fetch_addr;
                end
                GNT_HOST: begin
                    mem_en_r    <= 1'b1;
                    mem_we_r    <= host_we;
                    mem_addr_r  <= host_addr;
                    mem_wdata_r <= host_wdata;
                end
                default: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    vga_fb_tag_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush  (1'b0),
        .in_tag (push_tag_s),
        .out_tag(pipe_tag_s)
    );

    // Route the RAM word to its owner; data holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_r <= 1'b0;
            fetch_data_r  <= '0;
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= '0;
        end else begin
            fetch_valid_r <= (pipe_tag_s == TAG_FETCH);
            host_rvalid_r <= (pipe_tag_s == TAG_HOST);
            if (pipe_tag_s == TAG_FETCH) begin
                fetch_data_r <= mem_rdata;
            end else begin
                fetch_data_r <= fetch_data_r;
            end
            if (pipe_tag_s == TAG_HOST) begin
                host_rdata_r <= mem_rdata;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
        end
    end

    // Count consecutive refused host cycles; any accept or idle host clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (!host_valid || handshake_s) begin
            wait_cnt_r <= '0;
        end else if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Count fetches lost to a forced host grant, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_count_r <= 8'd0;
        end else if (drop_s && (miss_count_r != 8'hFF)) begin
            miss_count_r <= miss_count_r + 8'd1;
        end else begin
            miss_count_r <= miss_count_r;
        end
    end

    assign host_ready  = host_ready_s;
    assign mem_en      = mem_en_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign fetch_valid = fetch_valid_r;
    assign fetch_data  = fetch_data_r;
    assign host_rvalid = host_rvalid_r;
    assign host_rdata  = host_rdata_r;
    assign miss_count  = miss_count_r;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter. Two instances share the stimulus:
// dut0 (MAX_WAIT=0) and dut4 (MAX_WAIT=4); sel picks which one receives
// requests and which one's outputs are observed. Each has a 1-cycle RAM
// whose unwritten words read as addr[7:0] ^ 8'h79.
module tb_vga_fb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        fetch_req;
    logic [12:0] fetch_addr;
    logic        host_valid;
    logic        host_we;
    logic [12:0] host_addr;
    logic [7:0]  host_wdata;

    logic        fv0, hr0, hrv0, me0, mwe0;
    logic [7:0]  fd0, hrd0, mwd0, mrd0, mc0;
    logic [12:0] ma0;
    logic        fv4, hr4, hrv4, me4, mwe4;
    logic [7:0]  fd4, hrd4, mwd4, mrd4, mc4;
    logic [12:0] ma4;

    logic        o_fv, o_hr, o_hrv, o_me, o_mwe;
    logic [7:0]  o_fd, o_hrd, o_mwd, o_mc;
    logic [12:0] o_ma;

    int checks = 0;
    int errors = 0;

    bit [7:0] ram0 [0:8191];
    bit       wr0  [0:8191];
    bit [7:0] ram4 [0:8191];
    bit       wr4  [0:8191];

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ 8'h79;
    endfunction

    vga_fb_arbiter #(.ADDR_W(13), .DATA_W(8), .RAM_LAT(1), .MAX_WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req && !sel), .fetch_addr(fetch_addr),
        .fetch_valid(fv0), .fetch_data(fd0),
        .host_valid(host_valid && !sel), .host_ready(hr0),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(hrv0), .host_rdata(hrd0),
        .mem_en(me0), .mem_we(mwe0), .mem_addr(ma0), .mem_wdata(mwd0),
        .mem_rdata(mrd0), .miss_count(mc0)
    );

    vga_fb_arbiter #(.ADDR_W(13), .DATA_W(8), .RAM_LAT(1), .MAX_WAIT(4)) dut4 (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req && sel), .fetch_addr(fetch_addr),
        .fetch_valid(fv4), .fetch_data(fd4),
        .host_valid(host_valid && sel), .host_ready(hr4),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(hrv4), .host_rdata(hrd4),
        .mem_en(me4), .mem_we(mwe4), .mem_addr(ma4), .mem_wdata(mwd4),
        .mem_rdata(mrd4), .miss_count(mc4)
    );

    assign o_fv  = sel ? fv4  : fv0;
    assign o_fd  = sel ? fd4  : fd0;
    assign o_hr  = sel ? hr4  : hr0;
    assign o_hrv = sel ? hrv4 : hrv0;
    assign o_hrd = sel ? hrd4 : hrd0;
    assign o_me  = sel ? me4  : me0;
    assign o_mwe = sel ? mwe4 : mwe0;
    assign o_ma  = sel ? ma4  : ma0;
    assign o_mwd = sel ? mwd4 : mwd0;
    assign o_mc  = sel ? mc4  : mc0;

    // RAM model for dut0: 1-cycle read latency, write without response.
    always @(posedge clk) begin
        if (me0) begin
            if (mwe0) begin
                ram0[ma0] <= mwd0;
                wr0[ma0]  <= 1'b1;
            end else begin
                mrd0 <= wr0[ma0] ? ram0[ma0] : pat(ma0);
            end
        end
    end

    // RAM model for dut4.
    always @(posedge clk) begin
        if (me4) begin
            if (mwe4) begin
                ram4[ma4] <= mwd4;
                wr4[ma4]  <= 1'b1;
            end else begin
                mrd4 <= wr4[ma4] ? ram4[ma4] : pat(ma4);
            end
        end
    end

    task automatic idle_inputs();
        fetch_req  = 1'b0;
        fetch_addr = 13'h0000;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = 13'h0000;
        host_wdata = 8'h00;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sel   = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (o_me !== 1'b0)  begin errors++; $display("FAIL reset mem_en got %b exp 0", o_me); end
        checks++; if (o_fv !== 1'b0)  begin errors++; $display("FAIL reset fetch_valid got %b exp 0", o_fv); end
        checks++; if (o_hrv !== 1'b0) begin errors++; $display("FAIL reset host_rvalid got %b exp 0", o_hrv); end
        checks++; if (o_hr !== 1'b0)  begin errors++; $display("FAIL reset host_ready got %b exp 0", o_hr); end
        checks++; if (mc0 !== 8'd0 || mc4 !== 8'd0) begin errors++; $display("FAIL reset miss_count got %0d/%0d exp 0", mc0, mc4); end
        checks++; if (me4 !== 1'b0)   begin errors++; $display("FAIL reset dut4 mem_en got %b exp 0", me4); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (o_hr !== 1'b1)  begin errors++; $display("FAIL idle host_ready got %b exp 1", o_hr); end
        next_cycle();
    endtask

    task automatic test_fetch_basic();
        sel = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 13'h0123;
        @(negedge clk);
        checks++; if (o_fv !== 1'b0) begin errors++; $display("FAIL fetch t0 fetch_valid got %b exp 0", o_fv); end
        next_cycle();
        fetch_req = 1'b0;
        @(negedge clk);
        checks++; if (o_me !== 1'b1 || o_mwe !== 1'b0) begin errors++; $display("FAIL fetch t1 mem_en/we got %b/%b exp 1/0", o_me, o_mwe); end
        checks++; if (o_ma !== 13'h0123) begin errors++; $display("FAIL fetch t1 mem_addr got %h exp 0123", o_ma); end
        next_cycle();
        @(negedge clk);
        checks++; if (o_fv !== 1'b0 || o_me !== 1'b0) begin errors++; $display("FAIL fetch t2 fetch_valid/mem_en got %b/%b exp 0/0", o_fv, o_me); end
        next_cycle();
        @(negedge clk);
        checks++; if (o_fv !== 1'b1 || o_fd !== 8'h5A) begin errors++; $display("FAIL fetch t3 valid/data got %b/%h exp 1/5a", o_fv, o_fd); end
        next_cycle();
        @(negedge clk);
        checks++; if (o_fv !== 1'b0) begin errors++; $display("FAIL fetch t4 fetch_valid got %b exp 0", o_fv); end
    endtask

    task automatic test_host_wr_rd();
        sel = 1'b0;
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 13'h0040;
        host_wdata = 8'hC3;
        @(negedge clk);
        checks++; if (o_hr !== 1'b1) begin errors++; $display("FAIL host_wr host_ready got %b exp 1", o_hr); end
        next_cycle();
        host_we    = 1'b0;
        host_wdata = 8'h00;
        @(negedge clk);
        checks++; if (o_me !== 1'b1 || o_mwe !== 1'b1 || o_ma !== 13'h0040 || o_mwd !== 8'hC3) begin
            errors++; $display("FAIL host_wr mem cmd got en=%b we=%b a=%h d=%h exp 1 1 0040 c3", o_me, o_mwe, o_ma, o_mwd);
        end
        checks++; if (o_hr !== 1'b1) begin errors++; $display("FAIL host_rd host_ready got %b exp 1", o_hr); end
        next_cycle();
        host_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_me !== 1'b1 || o_mwe !== 1'b0) begin errors++; $display("FAIL host_rd mem en/we got %b/%b exp 1/0", o_me, o_mwe); end
        next_cycle();
        @(negedge clk);
        checks++; if (o_hrv !== 1'b0) begin errors++; $display("FAIL host_rd early rvalid got %b exp 0", o_hrv); end
        next_cycle();
        @(negedge clk);
        checks++; if (o_hrv !== 1'b1 || o_hrd !== 8'hC3) begin errors++; $display("FAIL host_rd rvalid/rdata got %b/%h exp 1/c3", o_hrv, o_hrd); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic       exp_hr, exp_fv, exp_hrv;
        logic [7:0] exp_fd;
        sel = 1'b0;
        for (int c = 0; c < 10; c++) begin
            fetch_req  = (c < 5);
            fetch_addr = 13'h0100 + 13'(c);
            host_valid = (c <= 5);
            host_we    = 1'b0;
            host_addr  = 13'h0040;
            exp_hr  = (c >= 5);
            exp_fv  = (c >= 3) && (c <= 7);
            exp_fd  = pat(13'h0100 + 13'(c - 3));
            exp_hrv = (c == 8);
            @(negedge clk);
            checks++; if (o_hr !== exp_hr) begin errors++; $display("FAIL contention c=%0d host_ready got %b exp %b", c, o_hr, exp_hr); end
            checks++; if (o_fv !== exp_fv || (exp_fv && o_fd !== exp_fd)) begin
                errors++; $display("FAIL contention c=%0d fetch valid/data got %b/%h exp %b/%h", c, o_fv, o_fd, exp_fv, exp_fd);
            end
            checks++; if (o_hrv !== exp_hrv || (exp_hrv && o_hrd !== 8'hC3)) begin
                errors++; $display("FAIL contention c=%0d host rvalid/rdata got %b/%h exp %b/c3", c, o_hrv, o_hrd, exp_hrv);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_forced();
        logic        exp_hr, exp_fv, exp_hrv, exp_me;
        logic [7:0]  exp_fd, exp_mc;
        logic [12:0] exp_ma;
        int          k;
        sel = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fetch_req  = (c < 8);
            fetch_addr = 13'h0200 + 13'(c);
            host_valid = (c <= 4);
            host_we    = 1'b0;
            host_addr  = 13'h0300;
            exp_hr  = (c == 4) || (c >= 8);
            k       = c - 3;
            exp_fv  = (k >= 0) && (k <= 7) && (k != 4);
            exp_fd  = pat(13'h0200 + 13'(k));
            exp_hrv = (c == 7);
            exp_mc  = (c >= 5) ? 8'd1 : 8'd0;
            k       = c - 1;
            exp_me  = (k >= 0) && (k <= 7);
            exp_ma  = (k == 4) ? 13'h0300 : 13'h0200 + 13'(k);
            @(negedge clk);
            checks++; if (o_hr !== exp_hr) begin errors++; $display("FAIL forced c=%0d host_ready got %b exp %b", c, o_hr, exp_hr); end
            checks++; if (o_fv !== exp_fv || (exp_fv && o_fd !== exp_fd)) begin
                errors++; $display("FAIL forced c=%0d fetch valid/data got %b/%h exp %b/%h", c, o_fv, o_fd, exp_fv, exp_fd);
            end
            checks++; if (o_hrv !== exp_hrv || (exp_hrv && o_hrd !== 8'h79)) begin
                errors++; $display("FAIL forced c=%0d host rvalid/rdata got %b/%h exp %b/79", c, o_hrv, o_hrd, exp_hrv);
            end
            checks++; if (o_mc !== exp_mc) begin errors++; $display("FAIL forced c=%0d miss_count got %0d exp %0d", c, o_mc, exp_mc); end
            if (c >= 1) begin
                checks++; if (o_me !== exp_me || (exp_me && o_ma !== exp_ma)) begin
                    errors++; $display("FAIL forced c=%0d mem en/addr got %b/%h exp %b/%h", c, o_me, o_ma, exp_me, exp_ma);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic       exp_fv, exp_hrv;
        logic [7:0] exp_d;
        int         r;
        sel = 1'b0;
        for (int c = 0; c < 12; c++) begin
            fetch_req  = (c < 8) && (c % 2 == 0);
            host_valid = (c < 8) && (c % 2 == 1);
            host_we    = 1'b0;
            fetch_addr = 13'h0010 + 13'(c);
            host_addr  = 13'h0020 + 13'(c);
            r       = c - 3;
            exp_fv  = (r >= 0) && (r < 8) && (r % 2 == 0);
            exp_hrv = (r >= 0) && (r < 8) && (r % 2 == 1);
            exp_d   = exp_fv ? pat(13'h0010 + 13'(r)) : pat(13'h0020 + 13'(r));
            @(negedge clk);
            if (c < 8) begin
                checks++; if (o_hr !== (c % 2 == 1)) begin errors++; $display("FAIL b2b c=%0d host_ready got %b", c, o_hr); end
            end
            checks++; if (o_fv !== exp_fv || (exp_fv && o_fd !== exp_d)) begin
                errors++; $display("FAIL b2b c=%0d fetch valid/data got %b/%h exp %b/%h", c, o_fv, o_fd, exp_fv, exp_d);
            end
            checks++; if (o_hrv !== exp_hrv || (exp_hrv && o_hrd !== exp_d)) begin
                errors++; $display("FAIL b2b c=%0d host rvalid/rdata got %b/%h exp %b/%h", c, o_hrv, o_hrd, exp_hrv, exp_d);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        for (int c = 0; c < 10; c++) begin
            fetch_req  = (c < 3);
            fetch_addr = 13'h0400 + 13'(c);
            reset      = (c == 3);
            @(negedge clk);
            if (c == 3) begin
                checks++; if (o_hr !== 1'b0) begin errors++; $display("FAIL reset_mid host_ready in reset got %b exp 0", o_hr); end
                checks++; if (o_me !== 1'b1 || o_mc !== 8'd1) begin
                    errors++; $display("FAIL reset_mid pre-reset mem_en/miss got %b/%0d exp 1/1", o_me, o_mc);
                end
            end
            if (c >= 4) begin
                checks++; if (o_fv !== 1'b0 || o_hrv !== 1'b0) begin
                    errors++; $display("FAIL reset_mid c=%0d valid pulses got %b/%b exp 0/0", c, o_fv, o_hrv);
                end
                checks++; if (o_me !== 1'b0 || o_mc !== 8'd0) begin
                    errors++; $display("FAIL reset_mid c=%0d mem_en/miss got %b/%0d exp 0/0", c, o_me, o_mc);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch_basic();
        test_host_wr_rd();
        test_contention();
        test_forced();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between the VGA scanout fetch path and a host (CPU/loader) read/write port.
- Sits between the sync/pixel counter plus scanout logic and the framebuffer RAM.
- Scanout has fixed priority with guaranteed fixed latency; host traffic fills the remaining cycles.
- An optional starvation guard forces host service; each fetch it drops is counted.

Parameters:
- ADDR_W, 13, framebuffer word address width (80x60 cells = 4800 words)
- DATA_W, 8, framebuffer word width
- RAM_LAT, 1, RAM read latency in cycles, from registered mem_en to valid mem_rdata; legal 1..3
- MAX_WAIT, 0, consecutive denied host cycles before a forced host grant; 0 disables the guard

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fetch_req  in  1  scanout read request, single-cycle pulse, no handshake
- fetch_addr  in  ADDR_W  scanout read address
- fetch_valid  out  1  scanout read data valid, single-cycle pulse
- fetch_data  out  DATA_W  scanout read data
- host_valid  in  1  host command valid
- host_ready  out  1  host command accepted this cycle (combinational)
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_rvalid  out  1  host read data valid, single-cycle pulse; host must sink it
- host_rdata  out  DATA_W  host read data
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data
- miss_count  out  8  saturating count of fetches dropped by the starvation guard

Behaviour:
- Reset: all outputs 0; the tag pipeline, wait counter and miss_count are cleared.
- Grant decision, cycle t, at most one winner:
  - force = (MAX_WAIT != 0) && (wait_cnt == MAX_WAIT) && host_valid
  - FETCH if fetch_req && !force
  - HOST if host_valid && (!fetch_req || force)
  - otherwise IDLE
- host_ready = host_valid-independent term (!fetch_req || force) && !reset. Handshake occurs when host_valid && host_ready. host_ready must not depend combinationally on host_valid except through force.
- RAM command issue:
  - The winner at t drives mem_en/mem_we/mem_addr/mem_wdata at t+1.
  - IDLE drives mem_en=0, mem_we=0; address and data hold their last values.
  - Host writes complete with no response.
- Read tags:
  - Each read grant pushes a tag {FETCH | HOST_RD} into a shift pipeline of depth RAM_LAT+1. mem_rdata is sampled at t+1+RAM_LAT.
  - fetch_valid/fetch_data or host_rvalid/host_rdata is registered at t+2+RAM_LAT.
  - Total latency = RAM_LAT+2 cycles (3 at default), constant, independent of host traffic.
  - Back-to-back reads sustain one response per cycle, in order.
- Wait counter:
  - Increments when host_valid && !host_ready, saturating at MAX_WAIT.
  - Clears on host handshake or when !host_valid.
- Forced grant: a fetch_req arriving in a force cycle is dropped. No fetch_valid is produced for it, and miss_count increments, saturating at 255.
- Simultaneous fetch_req and host_valid without force: fetch wins; host_ready=0; the host must hold its command stable.
- fetch_req while the tag pipeline is full of reads: legal, pipelined, no stall.
- Reset mid-operation:
  - Pending tags are flushed.
  - No fetch_valid or host_rvalid is emitted for commands issued before reset.
  - mem_en=0 from the cycle after reset is sampled.
- Address arithmetic: addresses pass unmodified; no wrap or bounds check. Out-of-range handling is the RAM's responsibility.

Decomposition:
- Package vga_fb_pkg holds:
  - typedef enum {GNT_IDLE, GNT_FETCH, GNT_HOST} grant_t
  - typedef enum {TAG_NONE, TAG_FETCH, TAG_HOST} tag_t
  - constants FB_COLS=80, FB_ROWS=60, FB_WORDS=4800
- One natural sub-module, vga_fb_tag_pipe: parameterised-depth tag shift register with synchronous flush, also used by future fetch paths.

Test Plan:
- Reset, then fetch_req at t=10 with addr 0x0123, RAM word 0x5A → mem_en=1, addr 0x0123 at t=11; fetch_valid=1, data 0x5A at t=13 only.
- Host write addr 0x0040, data 0xC3 with no fetch, then host read of 0x0040 → write accepted immediately; host_rvalid with 0xC3 three cycles after the read handshake.
- fetch_req and host_valid together for 5 cycles with MAX_WAIT=0 → host_ready=0 throughout; 5 fetch_valid pulses; host accepted in cycle 6.
- MAX_WAIT=4, continuous fetch_req, host_valid held → host accepted on the 5th cycle; that fetch is dropped; miss_count=1; fetch resumes next cycle.
- Reads alternating fetch/host for 8 cycles → responses in issue order, one per cycle, each on the correct output.
- reset asserted 1 cycle after 3 reads are issued → no valid pulses afterward; miss_count=0; mem_en=0.
